// File: rtl/memx_arbiter.sv
// Round-robin arbiter that lets two request channels share a single mem_controller port.
// Each granted access is latched and held until the controller completes it or a timeout fires.
module memx_arbiter #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int START_TIMEOUT = 16,
    parameter int DONE_TIMEOUT  = 1048575
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_rd_i,
    input  logic [1:0]              req_wr_i,
    input  logic [2*ADDR_WIDTH-1:0] req_adr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdt_i,
    output logic [1:0]              req_gnt_o,
    output logic [1:0]              req_done_o,
    output logic [1:0]              req_err_o,
    output logic [DATA_WIDTH-1:0]   req_rdt_o,
    output logic                    req_wok_o,
    output logic                    memx_rd_o,
    output logic                    memx_wr_o,
    output logic [ADDR_WIDTH-1:0]   memx_adr_o,
    output logic [DATA_WIDTH-1:0]   memx_wdt_o,
    input  logic                    memx_busy_i,
    input  logic [DATA_WIDTH-1:0]   memx_rdt_i,
    input  logic                    memx_wok_i,
    output logic                    arb_busy_o,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = 20;
    localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] DONE_LIM  = CW'(DONE_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            req;
    logic                  grant, gnt_ch, timeout;
    logic                  ch_q, lg_q, op_rd_q, err_q, wok_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdt_q, cap_q, rdt_q;
    logic [CW-1:0]         cnt_q;
    logic [1:0]            ch_vec;

    assign req = req_rd_i | req_wr_i;

    // Handshake: req_rd_i/req_wr_i are levels sampled only in IDLE; req_gnt_o pulses in the
    // cycle the request is latched, after which the channel may drop it. req_done_o pulses
    // once per granted access; the channel's request is ignored until the FSM is back in IDLE.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_ch  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00 && !rst_i) begin
                    grant   = 1'b1;
                    gnt_ch  = (req == 2'b11) ? ~lg_q : req[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (memx_busy_i) begin
                    state_d = WAIT;
                end else if (cnt_q == START_LIM) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            WAIT: begin
                if (!memx_busy_i) begin
                    state_d = DONE;
                end else if (cnt_q == DONE_LIM) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ch_q    <= 1'b0;
            lg_q    <= 1'b1;
            op_rd_q <= 1'b0;
            err_q   <= 1'b0;
            wok_q   <= 1'b0;
            adr_q   <= '0;
            wdt_q   <= '0;
            cap_q   <= '0;
            rdt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ch_q    <= gnt_ch;
                lg_q    <= gnt_ch;
                op_rd_q <= gnt_ch ? req_rd_i[1] : req_rd_i[0];
                adr_q   <= gnt_ch ? req_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_adr_i[ADDR_WIDTH-1:0];
                wdt_q   <= gnt_ch ? req_wdt_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdt_i[DATA_WIDTH-1:0];
                cnt_q   <= '0;
                err_q   <= 1'b0;
                wok_q   <= 1'b0;
            end
            if (state_q == ISSUE) begin
                cnt_q <= memx_busy_i ? '0 : cnt_q + 1'b1;
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                wok_q <= wok_q | memx_wok_i;
                if (memx_busy_i) cap_q <= memx_rdt_i;
            end
            if (timeout) err_q <= 1'b1;
            // Publish read data on DONE entry so it stays stable between completions.
            if (state_q != DONE && state_d == DONE) rdt_q <= cap_q;
        end
    end

    assign ch_vec      = ch_q ? 2'b10 : 2'b01;
    assign req_gnt_o   = grant ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
    assign req_done_o  = (state_q == DONE) ? ch_vec : 2'b00;
    assign req_err_o   = (state_q == DONE && err_q) ? ch_vec : 2'b00;
    assign req_rdt_o   = rdt_q;
    assign req_wok_o   = (state_q == DONE) && wok_q && !err_q && !op_rd_q;
    assign memx_rd_o   = (state_q == ISSUE || state_q == WAIT) && op_rd_q;
    assign memx_wr_o   = (state_q == ISSUE || state_q == WAIT) && !op_rd_q;
    assign memx_adr_o  = adr_q;
    assign memx_wdt_o  = wdt_q;
    assign arb_busy_o  = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
